// File: rtl/trig_pkg.sv
// Shared types and default timing constants for the trigger-level controls
// (also reused by the display/marker blocks).
package trig_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} trig_state_e;
    typedef enum logic [1:0] {NONE, UP, DN}       trig_req_e;

    localparam int unsigned DEF_LEVEL_W      = 12;
    localparam int unsigned DEF_STEP         = 256;
    localparam int unsigned DEF_RESET_LEVEL  = 1536;
    localparam int unsigned DEF_DEBOUNCE_CYC = 10000;
    localparam int unsigned DEF_HOLD_CYC     = 5000000;
    localparam int unsigned DEF_REPEAT_CYC   = 1000000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus debouncer for one active-low push button.
// pressed_o is the debounced level, 1 = pressed.
module button_debounce
    import trig_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic button_n_i,
    output logic pressed_o
);

    localparam int unsigned   CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          meta_q, sync_q;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised input disagrees with the
    // accepted state, so any bounce back restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        if (sync_q != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= ~button_n_i;
            sync_q  <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed_o = state_q;

endmodule

// File: rtl/trigger_level_ctrl.sv
// Trigger-threshold controller: two debounced buttons step a saturating level,
// with a single step on press and auto-repeat while held.
module trigger_level_ctrl
    import trig_pkg::*;
#(
    parameter int unsigned LEVEL_W      = DEF_LEVEL_W,
    parameter int unsigned STEP         = DEF_STEP,
    parameter int unsigned RESET_LEVEL  = DEF_RESET_LEVEL,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               button_u,
    input  logic               button_d,
    output logic [LEVEL_W-1:0] TRIG,
    output logic               LEVEL_STB,
    output logic               AT_MAX,
    output logic               AT_MIN
);

    localparam int unsigned TMAX = max3(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC);
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]      HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0]      REP_LAST  = TW'(REPEAT_CYC - 1);
    localparam logic [LEVEL_W-1:0] LMAX      = {LEVEL_W{1'b1}};
    localparam logic [LEVEL_W-1:0] RST_LVL   = LEVEL_W'(RESET_LEVEL);
    localparam logic [LEVEL_W:0]   STEP_W    = (LEVEL_W + 1)'(STEP);

    logic up_pressed, dn_pressed;

    button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up (
        .clk_i      (CLK),
        .rst_i      (RST),
        .button_n_i (button_u),
        .pressed_o  (up_pressed)
    );

    button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_dn (
        .clk_i      (CLK),
        .rst_i      (RST),
        .button_n_i (button_d),
        .pressed_o  (dn_pressed)
    );

    trig_req_e          req, dir_q, dir_d;
    trig_state_e        state_q, state_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic               step;
    logic [LEVEL_W:0]   sum, diff;
    logic [LEVEL_W-1:0] trig_q, lvl_d;
    logic               stb_q, at_max_q, at_min_q;

    always_comb begin
        req = NONE;
        if (up_pressed && !dn_pressed) req = UP;
        if (dn_pressed && !up_pressed) req = DN;
    end

    // dir_q is only meaningful outside IDLE; any change of request there,
    // including to NONE, drops back to IDLE without stepping.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        dir_d   = dir_q;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req != NONE) begin
                    step    = 1'b1;
                    dir_d   = req;
                    state_d = HOLD;
                    tmr_d   = '0;
                end
            end
            HOLD: begin
                if (req != dir_q) begin
                    state_d = IDLE;
                end else if (tmr_q == HOLD_LAST) begin
                    step    = 1'b1;
                    state_d = REPEAT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            REPEAT: begin
                if (req != dir_q) begin
                    state_d = IDLE;
                end else if (tmr_q == REP_LAST) begin
                    step  = 1'b1;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One extra bit catches carry-out (up) and borrow (down) for clamping.
    always_comb begin
        sum   = {1'b0, trig_q} + STEP_W;
        diff  = {1'b0, trig_q} - STEP_W;
        lvl_d = trig_q;
        if (step) begin
            if (dir_d == UP) lvl_d = sum[LEVEL_W]  ? LMAX : sum[LEVEL_W-1:0];
            else             lvl_d = diff[LEVEL_W] ? '0   : diff[LEVEL_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            dir_q    <= NONE;
            tmr_q    <= '0;
            trig_q   <= RST_LVL;
            stb_q    <= 1'b0;
            at_max_q <= (RST_LVL == LMAX);
            at_min_q <= (RST_LVL == '0);
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            tmr_q    <= tmr_d;
            trig_q   <= lvl_d;
            stb_q    <= (lvl_d != trig_q);
            at_max_q <= (lvl_d == LMAX);
            at_min_q <= (lvl_d == '0);
        end
    end

    assign TRIG      = trig_q;
    assign LEVEL_STB = stb_q;
    assign AT_MAX    = at_max_q;
    assign AT_MIN    = at_min_q;

endmodule

// File: tb/tb_trigger_level_ctrl.sv
// Bench for trigger_level_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a behavioural press/age model.
module tb_trigger_level_ctrl;

    localparam int LW    = 12;
    localparam int STEP  = 256;
    localparam int RLVL  = 1536;
    localparam int DEB   = 4;
    localparam int HOLD  = 20;
    localparam int REP   = 8;
    localparam int LMAX  = (1 << LW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          button_u = 1'b1;
    logic          button_d = 1'b1;
    logic [LW-1:0] TRIG;
    logic          LEVEL_STB, AT_MAX, AT_MIN;

    trigger_level_ctrl #(
        .LEVEL_W(LW), .STEP(STEP), .RESET_LEVEL(RLVL),
        .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
    ) dut (
        .CLK(CLK), .RST(RST), .button_u(button_u), .button_d(button_d),
        .TRIG(TRIG), .LEVEL_STB(LEVEL_STB), .AT_MAX(AT_MAX), .AT_MIN(AT_MIN)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;
    int stb_cnt = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: pressed levels seen through a 2-cycle delay line,
    // accepted after DEB consecutive disagreeing cycles; a held direction
    // steps at age 0, age HOLD, then every REP cycles.
    int m_lvl = RLVL;
    bit m_stb = 0;
    bit m_dl_u[2], m_dl_d[2];
    bit m_pu = 0, m_pd = 0;
    int m_ru = 0, m_rd = 0;
    bit m_act = 0;
    int m_dir = 0;
    int m_age = 0;

    task automatic model_edge();
        int req;
        bit st;
        int nl;
        if (RST) begin
            m_lvl = RLVL; m_stb = 0;
            m_dl_u = '{0, 0}; m_dl_d = '{0, 0};
            m_pu = 0; m_pd = 0; m_ru = 0; m_rd = 0;
            m_act = 0; m_dir = 0; m_age = 0;
            return;
        end
        req = (m_pu && !m_pd) ? 1 : ((m_pd && !m_pu) ? 2 : 0);
        st = 0;
        if (m_act && req == m_dir) begin
            m_age++;
            st = (m_age == HOLD) || (m_age > HOLD && (m_age - HOLD) % REP == 0);
        end else if (m_act) begin
            m_act = 0;
        end else if (req != 0) begin
            m_act = 1; m_dir = req; m_age = 0; st = 1;
        end
        nl = m_lvl;
        if (st) nl = (m_dir == 1) ? ((m_lvl + STEP > LMAX) ? LMAX : m_lvl + STEP)
                                  : ((m_lvl - STEP < 0) ? 0 : m_lvl - STEP);
        m_stb = (nl != m_lvl);
        m_lvl = nl;
        if (m_dl_u[1] != m_pu) begin
            m_ru++;
            if (m_ru == DEB) begin m_pu = m_dl_u[1]; m_ru = 0; end
        end else m_ru = 0;
        if (m_dl_d[1] != m_pd) begin
            m_rd++;
            if (m_rd == DEB) begin m_pd = m_dl_d[1]; m_rd = 0; end
        end else m_rd = 0;
        m_dl_u[1] = m_dl_u[0]; m_dl_u[0] = !button_u;
        m_dl_d[1] = m_dl_d[0]; m_dl_d[0] = !button_d;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        chk("m_trig",   int'(TRIG),      m_lvl);
        chk("m_stb",    int'(LEVEL_STB), int'(m_stb));
        chk("m_at_max", int'(AT_MAX),    int'(m_lvl == LMAX));
        chk("m_at_min", int'(AT_MIN),    int'(m_lvl == 0));
        if (LEVEL_STB) stb_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        int ev;
        bit es;

        // Reset
        do_reset();
        chk("rst_trig", int'(TRIG), 1536);
        chk("rst_stb", int'(LEVEL_STB), 0);
        chk("rst_max", int'(AT_MAX), 0);
        chk("rst_min", int'(AT_MIN), 0);
        ticks(3);

        // Single press: 10 cycles low, step lands exactly 7 cycles later
        button_u = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6) chk("sp_before", int'(TRIG), 1536);
            if (k == 7) begin
                chk("sp_trig", int'(TRIG), 1792);
                chk("sp_stb", int'(LEVEL_STB), 1);
            end
            if (k == 8) chk("sp_stb_off", int'(LEVEL_STB), 0);
        end
        button_u = 1'b1;
        stb_cnt = 0;
        ticks(40);
        chk("sp_hold_trig", int'(TRIG), 1792);
        chk("sp_no_more", stb_cnt, 0);

        // Glitch rejection
        do_reset();
        button_d = 1'b0;
        stb_cnt = 0;
        ticks(3);
        button_d = 1'b1;
        ticks(20);
        chk("gl_trig", int'(TRIG), 1536);
        chk("gl_stb", stb_cnt, 0);

        // Auto-repeat into the top clamp
        ev = 1536;
        button_u = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            tick();
            es = (k == 7) || (k >= 27 && k <= 91 && (k - 27) % 8 == 0);
            if (es) ev = (ev + 256 > 4095) ? 4095 : ev + 256;
            chk("ar_stb", int'(LEVEL_STB), int'(es));
            chk("ar_trig", int'(TRIG), ev);
        end
        chk("ar_max", int'(AT_MAX), 1);
        button_u = 1'b1;
        ticks(20);

        // Floor clamp: walk down to 256, then two separate presses
        do_reset();
        button_d = 1'b0;
        ticks(52);
        chk("fl_256", int'(TRIG), 256);
        button_d = 1'b1;
        ticks(20);
        chk("fl_256_held", int'(TRIG), 256);
        stb_cnt = 0;
        button_d = 1'b0; ticks(10); button_d = 1'b1; ticks(20);
        chk("fl_p1_trig", int'(TRIG), 0);
        chk("fl_p1_stb", stb_cnt, 1);
        chk("fl_p1_min", int'(AT_MIN), 1);
        stb_cnt = 0;
        button_d = 1'b0; ticks(10); button_d = 1'b1; ticks(20);
        chk("fl_p2_trig", int'(TRIG), 0);
        chk("fl_p2_stb", stb_cnt, 0);

        // Both held: no stepping; then reset while held restarts debounce
        do_reset();
        button_u = 1'b0;
        ticks(30);
        chk("sim_rep", int'(TRIG), 2048);
        button_d = 1'b0;
        ticks(10);
        chk("sim_last", int'(TRIG), 2304);
        stb_cnt = 0;
        ticks(30);
        chk("sim_frozen", int'(TRIG), 2304);
        chk("sim_no_stb", stb_cnt, 0);
        RST = 1'b1;
        tick();
        chk("mid_rst_trig", int'(TRIG), 1536);
        chk("mid_rst_stb", int'(LEVEL_STB), 0);
        RST = 1'b0;
        button_d = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) chk("mid_rst_wait", int'(TRIG), 1536);
            if (k == 7) chk("mid_rst_step", int'(TRIG), 1792);
        end
        button_u = 1'b1;
        ticks(20);

        // Random traffic, including glitches, long holds and resets
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 24) == 0) begin
                RST = 1'b1; tick(); RST = 1'b0;
            end
            button_u = ($urandom_range(0, 2) != 0);
            button_d = ($urandom_range(0, 2) != 0);
            ticks($urandom_range(1, 80));
        end
        button_u = 1'b1;
        button_d = 1'b1;
        ticks(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/trigger_level_ctrl.md
# trigger_level_ctrl

Parametrised trigger-level controller: converts the two active-low front-panel push buttons into a saturating trigger-threshold word for the oscilloscope trigger comparator. Each button is synchronised and debounced. A single step is taken on press, and auto-repeat stepping applies while a button is held. Level width, step size, reset level and all timing constants are generics.

## Interface
- `LEVEL_W`, 12: width of the trigger level output.
- `STEP`, 256: increment/decrement per accepted step; must satisfy 1 ≤ STEP < 2^LEVEL_W.
- `RESET_LEVEL`, 1536: level loaded on reset.
- `DEBOUNCE_CYC`, 10000: consecutive stable cycles required before a button change is accepted.
- `HOLD_CYC`, 5000000: held cycles after the first step before auto-repeat starts.
- `REPEAT_CYC`, 1000000: cycles between auto-repeat steps.
- `CLK` input 1: the only clock.
- `RST` input 1: reset, synchronous, active-high.
- `button_u` input 1: raw up button, active-low, asynchronous to CLK.
- `button_d` input 1: raw down button, active-low, asynchronous to CLK.
- `TRIG` output LEVEL_W: current trigger level, registered.
- `LEVEL_STB` output 1: one-cycle pulse in the cycle TRIG takes a new value.
- `AT_MAX` output 1: TRIG == 2^LEVEL_W−1.
- `AT_MIN` output 1: TRIG == 0.

## Operation
- **Input conditioning**, per button:
  - Two-flop synchroniser, inverted so 1 = pressed.
  - Debouncer: a counter runs while the synchronised value differs from the debounced state and clears when they match.
  - The debounced state toggles when the counter reaches DEBOUNCE_CYC−1.
- **Request decode:**
  - up-only pressed → UP
  - down-only pressed → DN
  - both or none → NONE
- **FSM states:**
  - **IDLE**: UP/DN → apply step, go to HOLD, clear the timer.
  - **HOLD**: request unchanged → count; at HOLD_CYC−1 apply step, go to REPEAT, clear the timer. Request NONE or changed → IDLE.
  - **REPEAT**: request unchanged → count; at REPEAT_CYC−1 apply step, clear the timer. Request NONE or changed → IDLE.
- **Step arithmetic:** computed at LEVEL_W+1 bits.
  - UP: TRIG+STEP, clamped to 2^LEVEL_W−1.
  - DN: TRIG−STEP, clamped to 0.
- **LEVEL_STB** asserts only when the value actually changes. A step attempted while saturated gives no strobe, but the FSM still advances.
- **Direction change:** pressing the second button while the first is held yields NONE → IDLE, with no step. Releasing one of the two yields a fresh UP/DN from IDLE.
- **Reset:** synchronous, overrides everything.
  - TRIG = RESET_LEVEL, LEVEL_STB = 0.
  - AT_MAX/AT_MIN are decoded from RESET_LEVEL.
  - FSM = IDLE; timers and debounce counters = 0; debounced states = released; synchroniser flops = released.
  - A button held through reset is accepted as a new press DEBOUNCE_CYC cycles after the synchronised value shows pressed.
- **Reset mid-hold or mid-repeat:** the level is restored to RESET_LEVEL and no pending step is applied.

## Timing
- Latency from raw edge to TRIG update: 2 (synchroniser) + DEBOUNCE_CYC (debounce) + 1 (FSM/level register) cycles.
- TRIG and LEVEL_STB change on the same CLK edge.
- AT_MAX and AT_MIN are registered alongside TRIG, so there is no lag.
- Glitches shorter than DEBOUNCE_CYC cycles are ignored entirely.
- First auto-repeat step occurs HOLD_CYC cycles after the initial step.
- Subsequent auto-repeat steps occur every REPEAT_CYC cycles.
- Maximum steady-state step rate while held: one step per REPEAT_CYC cycles.
- Timer width: clog2 of max(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC).

## Structure
- Shared package `trig_pkg`:
  - FSM state enum (IDLE, HOLD, REPEAT).
  - Request enum (NONE, UP, DN).
  - Default timing constants, reused by the display/marker blocks.
- Sub-module `button_debounce` (synchroniser + debouncer, parameter DEBOUNCE_CYC, output debounced pressed level), instantiated twice.
- The top module holds request decode, FSM, timer, saturating adder and flags.

## Test plan
Simulate with LEVEL_W=12, STEP=256, RESET_LEVEL=1536, DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=8.
- **Reset:** assert RST 1 cycle → TRIG=1536, LEVEL_STB=0, AT_MAX=0, AT_MIN=0.
- **Single press:**
  - Stimulus: button_u low for 10 cycles, then high.
  - TRIG=1792 exactly 7 cycles after the falling edge, with a one-cycle LEVEL_STB.
  - No further change.
- **Glitch rejection:** button_d low for 3 cycles → TRIG stays 1536, no strobe.
- **Auto-repeat and saturation:**
  - Stimulus: hold button_u.
  - Steps to 1792, then after 20 cycles 2048, then every 8 cycles to 3840.
  - Next step clamps at 4095 with AT_MAX=1.
  - Further repeats produce no strobe.
- **Floor clamp:** from TRIG=256, press button_d twice (released between presses) → 0 then 0; AT_MIN=1; strobe only on the first step.
- **Simultaneous and reset mid-operation:**
  - Hold button_u into REPEAT, then press button_d → no steps while both are held.
  - Assert RST while held → TRIG=1536, FSM restarts with a fresh debounce.
